// File: rtl/fp16_add_arbiter.sv
// Round-robin sharing of one fixed-latency FP16 adder among NUM_REQ requesters,
// with a tag return path, per-requester credits and sticky exception flags.
module fp16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 3,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  add_valid,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  input  logic [15:0]           add_result,
  input  logic [4:0]            add_flags,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_data,
  output logic [4:0]            resp_flags,
  output logic [5*NUM_REQ-1:0]  sticky_flags,
  input  logic [NUM_REQ-1:0]    flags_clr,
  output logic                  busy
);
  localparam int TW = $clog2(NUM_REQ);
  localparam int CW = 4;

  logic [TW-1:0]      rr_ptr;
  logic [CW-1:0]      out_cnt [NUM_REQ];
  logic [4:0]         sticky  [NUM_REQ];
  logic [15:0]        a_lane  [NUM_REQ];
  logic [15:0]        b_lane  [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  logic [TW-1:0]      grant_idx;
  logic [TW:0]        search_sum;
  logic [TW-1:0]      search_idx;
  logic [TW-1:0]      issue_tag;
  logic [ADD_LAT-1:0] tag_v;
  logic [TW-1:0]      tag_q [ADD_LAT];

  // Subtraction is folded into the operand lane by flipping B's sign.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[16*i +: 16];
    assign b_lane[i] = {req_b[16*i+15] ^ req_sub[i], req_b[16*i +: 15]};
    assign sticky_flags[5*i +: 5] = sticky[i];
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (out_cnt[i] < CW'(MAX_OUT));
  end

  // First eligible requester at or after the pointer, wrapping once.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    search_sum = '0;
    search_idx = '0;
    req_ready  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_sum = {1'b0, rr_ptr} + (TW+1)'(k);
      if (search_sum >= (TW+1)'(NUM_REQ))
        search_sum = search_sum - (TW+1)'(NUM_REQ);
      search_idx = search_sum[TW-1:0];
      if (!grant_any && eligible[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = search_idx;
      end
    end
    if (grant_any)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      issue_tag  <= '0;
      tag_v      <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      for (int k = 0; k < ADD_LAT; k++)
        tag_q[k] <= '0;
    end else begin
      add_valid <= grant_any;
      if (grant_any) begin
        add_a     <= a_lane[grant_idx];
        add_b     <= b_lane[grant_idx];
        issue_tag <= grant_idx;
        rr_ptr    <= (grant_idx == TW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // The tag rides alongside the adder so the last stage lines up with add_result.
      tag_v[0] <= add_valid;
      tag_q[0] <= issue_tag;
      for (int k = 1; k < ADD_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      resp_valid <= '0;
      if (tag_v[ADD_LAT-1]) begin
        resp_valid[tag_q[ADD_LAT-1]] <= 1'b1;
        resp_data                    <= add_result;
        resp_flags                   <= add_flags;
      end
    end
  end

  // A clear coinciding with a response keeps that response's flags.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        out_cnt[i] <= '0;
        sticky[i]  <= '0;
      end else begin
        if ((req_valid[i] && req_ready[i]) && !resp_valid[i])
          out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (!(req_valid[i] && req_ready[i]) && resp_valid[i])
          out_cnt[i] <= out_cnt[i] - 1'b1;
        if (resp_valid[i])
          sticky[i] <= (flags_clr[i] ? 5'b0 : sticky[i]) | resp_flags;
        else if (flags_clr[i])
          sticky[i] <= '0;
      end
    end
  end

  always_comb begin
    busy = add_valid || (|tag_v);
    for (int i = 0; i < NUM_REQ; i++)
      if (out_cnt[i] != '0)
        busy = 1'b1;
  end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: directed scenarios then random traffic, checked
// every cycle against a transaction-level model of grants, credits and flags.
module tb_fp16_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADD_LAT = 3;
  localparam int MAX_OUT = 2;
  localparam int DEPTH   = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_a = '0;
  logic [16*NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_sub = '0;
  logic                  add_valid;
  logic [15:0]           add_a;
  logic [15:0]           add_b;
  logic [15:0]           add_result;
  logic [4:0]            add_flags;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [15:0]           resp_data;
  logic [4:0]            resp_flags;
  logic [5*NUM_REQ-1:0]  sticky_flags;
  logic [NUM_REQ-1:0]    flags_clr = '0;
  logic                  busy;

  fp16_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_flags(add_flags),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .sticky_flags(sticky_flags), .flags_clr(flags_clr), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Stand-in adder: known FP16 sums for the directed cases, a fixed scramble otherwise.
  function automatic logic [20:0] adder_fn(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00 && b == 16'h3C00) return {16'h4000, 5'b00000};
    if (a == 16'h4200 && b == 16'hBC00) return {16'h4000, 5'b00000};
    if (a == 16'h7BFF && b == 16'h7BFF) return {16'h7C00, 5'b00101};
    if (a == 16'h3C00 && b == 16'h0001) return {16'h3C00, 5'b00001};
    return {a ^ {b[7:0], b[15:8]}, a[4:0] ^ b[9:5]};
  endfunction

  logic [20:0] ad_pipe [ADD_LAT];
  always @(posedge clk) begin
    ad_pipe[0] <= add_valid ? adder_fn(add_a, add_b) : 21'($urandom);
    for (int k = 1; k < ADD_LAT; k++)
      ad_pipe[k] <= ad_pipe[k-1];
  end
  assign add_result = ad_pipe[ADD_LAT-1][20:5];
  assign add_flags  = ad_pipe[ADD_LAT-1][4:0];

  int          m_out [NUM_REQ];
  int          m_ptr;
  logic [4:0]  m_sticky [NUM_REQ];
  bit          exp_av [DEPTH];
  logic [15:0] exp_aa [DEPTH];
  logic [15:0] exp_ab [DEPTH];
  bit          exp_rv [DEPTH];
  int          exp_rtag [DEPTH];
  logic [15:0] exp_rd [DEPTH];
  logic [4:0]  exp_rf [DEPTH];
  int          cyc, total, bad, ngr;
  logic [NUM_REQ-1:0] seen_grant;

  task automatic model_reset();
    m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_out[i]    = 0;
      m_sticky[i] = '0;
    end
    for (int s = 0; s < DEPTH; s++) begin
      exp_av[s] = 1'b0;
      exp_rv[s] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [16*NUM_REQ-1:0] rand_lanes();
    logic [16*NUM_REQ-1:0] v;
    for (int j = 0; j < NUM_REQ; j++)
      v[j*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic [16*NUM_REQ-1:0] a,
                               input logic [16*NUM_REQ-1:0] b, input logic [NUM_REQ-1:0] s,
                               input logic [NUM_REQ-1:0] c, input logic r);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_sub   = s;
    flags_clr = c;
    rst       = r;
  endtask

  // Checks this cycle's outputs against the model, then advances the model past the edge.
  task automatic checkOutput();
    logic [NUM_REQ-1:0]   g, rv_exp, live;
    logic [5*NUM_REQ-1:0] st_exp;
    logic [15:0]          ga, gb;
    logic [20:0]          res;
    int                   slot, gi, idx, s;
    bit                   busy_exp, dec;
    #1;
    slot = cyc % DEPTH;
    g = '0;
    gi = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (gi < 0 && req_valid[idx] && m_out[idx] < MAX_OUT) gi = idx;
    end
    if (gi >= 0) g[gi] = 1'b1;
    seen_grant = req_ready;
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("add_valid", 32'(add_valid), 32'(exp_av[slot]));
    if (exp_av[slot]) begin
      chk("add_a", 32'(add_a), 32'(exp_aa[slot]));
      chk("add_b", 32'(add_b), 32'(exp_ab[slot]));
    end
    rv_exp = '0;
    if (exp_rv[slot]) rv_exp[exp_rtag[slot]] = 1'b1;
    chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
    if (exp_rv[slot]) begin
      chk("resp_data", 32'(resp_data), 32'(exp_rd[slot]));
      chk("resp_flags", 32'(resp_flags), 32'(exp_rf[slot]));
    end
    total++;
    assert ($onehot0(resp_valid)) else begin
      bad++;
      $error("[TB] FAIL resp_onehot observed=0x%0h expected=onehot0 cycle=%0d", resp_valid, cyc);
    end
    live = '0;
    for (int i = 0; i < NUM_REQ; i++) live[i] = (m_out[i] > 0);
    total++;
    assert ((resp_valid & ~live) == '0) else begin
      bad++;
      $error("[TB] FAIL credit_underflow observed=0x%0h expected_subset_of=0x%0h cycle=%0d",
             resp_valid, live, cyc);
    end
    busy_exp = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      st_exp[5*i +: 5] = m_sticky[i];
      if (m_out[i] != 0) busy_exp = 1'b1;
    end
    chk("sticky_flags", 32'(sticky_flags), 32'(st_exp));
    chk("busy", 32'(busy), 32'(busy_exp));

    for (int i = 0; i < NUM_REQ; i++) begin
      dec = exp_rv[slot] && (exp_rtag[slot] == i);
      m_out[i] = m_out[i] + int'(g[i]) - int'(dec);
      if (dec && flags_clr[i])   m_sticky[i] = exp_rf[slot];
      else if (dec)              m_sticky[i] = m_sticky[i] | exp_rf[slot];
      else if (flags_clr[i])     m_sticky[i] = '0;
    end
    if (gi >= 0) begin
      ga = req_a[gi*16 +: 16];
      gb = req_b[gi*16 +: 16] ^ {req_sub[gi], 15'b0};
      s = (cyc + 1) % DEPTH;
      exp_av[s] = 1'b1;
      exp_aa[s] = ga;
      exp_ab[s] = gb;
      res = adder_fn(ga, gb);
      s = (cyc + 2 + ADD_LAT) % DEPTH;
      exp_rv[s]   = 1'b1;
      exp_rtag[s] = gi;
      exp_rd[s]   = res[20:5];
      exp_rf[s]   = res[4:0];
      m_ptr = (gi + 1) % NUM_REQ;
    end
    exp_av[slot] = 1'b0;
    exp_rv[slot] = 1'b0;
    if (rst) model_reset();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus('0, rand_lanes(), rand_lanes(), '0, '0, 1'b0);
      checkOutput();
    end
  endtask

  task automatic issue1(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16*NUM_REQ-1:0] va, vb;
    logic [NUM_REQ-1:0]    v, vs;
    va = rand_lanes();
    vb = rand_lanes();
    v  = '0;
    vs = NUM_REQ'($urandom);
    va[i*16 +: 16] = a;
    vb[i*16 +: 16] = b;
    v[i]  = 1'b1;
    vs[i] = s;
    applyStimulus(v, va, vb, vs, '0, 1'b0);
    checkOutput();
  endtask

  initial begin
    logic r;
    logic [NUM_REQ-1:0] v;
    total = 0;
    bad   = 0;
    cyc   = 0;
    ngr   = 0;
    model_reset();
    $display("[TB] fp16_add_arbiter bench start");
    @(negedge clk);

    // Reset values.
    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    checkOutput();

    // Fairness: everyone requesting, grants rotate from requester 0.
    for (int k = 0; k < 8; k++) begin
      applyStimulus('1, rand_lanes(), rand_lanes(), NUM_REQ'($urandom), '0, 1'b0);
      checkOutput();
      chk("rr_order", 32'(seen_grant), 32'(1) << (k % NUM_REQ));
    end
    idle(8);

    // Single add, then a subtract on requester 2.
    issue1(0, 16'h3C00, 16'h3C00, 1'b0);
    idle(5);
    chk("single_busy_low", 32'(busy), 32'(0));
    issue1(2, 16'h4200, 16'h3C00, 1'b1);
    idle(6);

    // Credit limit: requester 1 alone gets MAX_OUT grants before its first response.
    ngr = 0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(NUM_REQ'(2), rand_lanes(), rand_lanes(), '0, '0, 1'b0);
      checkOutput();
      if (k < 5) ngr += int'(seen_grant[1]);
    end
    chk("credit_grants", 32'(ngr), 32'(MAX_OUT));
    idle(8);

    // Sticky flags: clear alone, overflow accumulate, clear racing an inexact response.
    applyStimulus('0, '0, '0, '0, NUM_REQ'(1), 1'b0);
    checkOutput();
    chk("sticky_clr_alone", 32'(sticky_flags[4:0]), 32'(0));
    issue1(0, 16'h7BFF, 16'h7BFF, 1'b0);
    idle(5);
    chk("sticky_ovf", 32'(sticky_flags[4:0]), 32'(5'b00101));
    issue1(0, 16'h3C00, 16'h0001, 1'b0);
    idle(4);
    applyStimulus('0, '0, '0, '0, NUM_REQ'(1), 1'b0);
    checkOutput();
    chk("sticky_clr_with_resp", 32'(sticky_flags[4:0]), 32'(5'b00001));
    idle(3);

    // Reset with three operations in flight.
    issue1(0, 16'h1234, 16'h4321, 1'b0);
    issue1(1, 16'h5555, 16'h0AAA, 1'b1);
    issue1(2, 16'h3C00, 16'h3C00, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, 1'b1);
    checkOutput();
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk("rst_no_resp", 32'(resp_valid), 32'(0));
      chk("rst_not_busy", 32'(busy), 32'(0));
    end
    applyStimulus(NUM_REQ'(4'b1001), rand_lanes(), rand_lanes(), '0, '0, 1'b0);
    checkOutput();
    chk("rst_ptr_grant", 32'(seen_grant), 32'(1));
    idle(8);

    // Random traffic with occasional clears and resets.
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 99) == 0);
      v = r ? '0 : NUM_REQ'($urandom);
      applyStimulus(v, rand_lanes(), rand_lanes(), NUM_REQ'($urandom),
                    NUM_REQ'($urandom & $urandom & $urandom), r);
      checkOutput();
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
